// File: rtl/sdp_rd_pkg.sv
// ---------------------------------------------------------------------------
// sdp_rd_pkg
// Shared types and constants for the read-side streamer of the simple
// dual-port RAM. Imported by sdp_rd_fifo and sdp_rd_streamer.
//   rd_state_t : command sequencer states
//   FIFO_DEPTH : number of {last, data} entries in the output FIFO
//   RD_LAT     : registered read latency of the RAM, in read-clock cycles
// ---------------------------------------------------------------------------
package sdp_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_t;

    localparam int FIFO_DEPTH = 4;
    localparam int RD_LAT     = 1;

endpackage

// File: rtl/sdp_rd_fifo.sv
// ---------------------------------------------------------------------------
// sdp_rd_fifo
// Small synchronous FIFO holding {last, data} words between the RAM read
// pipeline and the valid/ready output stream. The head entry is presented
// combinationally, so the stream sees first-word-fall-through behaviour.
// DEPTH must be a power of two so the pointers can wrap by overflow.
// Ports:
//   clkb      in   read clock
//   rst       in   asynchronous reset, active-high; empties the FIFO
//   push      in   write push_data this cycle (ignored when full without pop)
//   push_data in   W-bit entry to store
//   pop       in   remove the head entry this cycle (ignored when empty)
//   head_data out  current head entry
//   empty     out  no entries stored
//   occ       out  number of entries stored, 0..DEPTH
// ---------------------------------------------------------------------------
module sdp_rd_fifo
    import sdp_rd_pkg::*;
#(
    parameter int W     = 5,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                       clkb,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               head_data,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     occ
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    // Qualify the requests so a stray push into a full FIFO or a pop from
    // an empty one can never corrupt the pointers. A push into a full FIFO
    // is still allowed when the head leaves in the same cycle.
    always_comb begin
        do_pop  = pop && (cnt != '0);
        do_push = push && ((cnt != (PW+1)'(DEPTH)) || do_pop);
    end

    // Pointer and occupancy bookkeeping; reset empties the FIFO without
    // touching the storage array.
    always_ff @(posedge clkb or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (PW+1)'(1);
                2'b01:   cnt <= cnt - (PW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage array has no reset: entries are only ever read once the
    // occupancy count says they were written.
    always_ff @(posedge clkb) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head_data = mem[rd_ptr];
    assign empty     = (cnt == '0);
    assign occ       = cnt;

endmodule

// File: rtl/sdp_rd_streamer.sv
// ---------------------------------------------------------------------------
// sdp_rd_streamer
// Read-side sequencer for the simple dual-port RAM, entirely in the read
// clock domain. A start command walks len consecutive addresses from base,
// absorbs the RAM's registered read latency and re-presents the data as a
// valid/ready stream with m_last on the final word. Reads are only issued
// while the FIFO plus in-flight words leave room, so backpressure never
// loses data and an unstalled stream runs at one word per cycle.
//
// Optional build macro:
//   SDP_RD_STREAMER_STALL_CNT_EN  adds the 16-bit saturating stall_cnt output
//
// Ports:
//   clkb      in   read clock
//   rst       in   asynchronous reset, active-high
//   start     in   command strobe, accepted only in IDLE
//   base      in   first read address (sampled with accepted start)
//   len       in   word count 0..2^AW (sampled with accepted start)
//   busy      out  command in progress
//   done      out  one-cycle completion pulse
//   reb       out  RAM read enable (registered)
//   addrb     out  RAM read address (registered)
//   doutb     in   RAM read data, valid one cycle after reb is sampled
//   m_valid   out  stream data valid
//   m_data    out  stream data
//   m_last    out  final word of a command
//   m_ready   in   stream sink ready
//   stall_cnt out  cycles with m_valid && !m_ready during a command (optional)
// ---------------------------------------------------------------------------
module sdp_rd_streamer
    import sdp_rd_pkg::*;
#(
    parameter int AW = 4,
    parameter int DW = 4
) (
    input  logic          clkb,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    output logic          reb,
    output logic [AW-1:0] addrb,
    input  logic [DW-1:0] doutb,
    output logic          m_valid,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    input  logic          m_ready
`ifdef SDP_RD_STREAMER_STALL_CNT_EN
   ,output logic [15:0]   stall_cnt
`endif
);

    // One stage for the registered reb, plus RD_LAT stages of RAM latency.
    localparam int          PEND_W  = RD_LAT + 1;
    localparam logic [AW:0] LEN_ONE = (AW+1)'(1);

    rd_state_t         state;
    rd_state_t         state_nxt;
    logic [AW:0]       rem;
    logic              busy_q;
    logic [PEND_W-1:0] pend;
    logic [PEND_W-1:0] pend_last;
    logic [2:0]        pend_cnt;
    logic [2:0]        occ;
    logic [3:0]        credit_sum;
    logic              credit_ok;
    logic              pop;
    logic              accept;
    logic              issue;
    logic              issue_last;
    logic              fifo_empty;
    logic [DW:0]       head;

    // Count the reads already launched but not yet pushed into the FIFO.
    always_comb begin
        pend_cnt = '0;
        for (int i = 0; i < PEND_W; i++) begin
            pend_cnt = pend_cnt + 3'(pend[i]);
        end
    end

    // A new read is allowed only if every word already committed (stored,
    // minus the one leaving now, plus those still in flight) leaves a free
    // slot. This makes FIFO overflow impossible under any backpressure.
    always_comb begin
        pop        = m_valid && m_ready;
        credit_sum = {1'b0, occ} - {3'b000, pop} + {1'b0, pend_cnt};
        credit_ok  = (credit_sum < 4'(FIFO_DEPTH));
    end

    // Next-state and issue decision. The accepting edge itself launches the
    // first read (the FIFO is always empty in IDLE), so RUN only handles the
    // remaining len-1 words. RUN leaves at the edge that registers the last
    // read; a len of 1 spends one idle RUN cycle before moving on.
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        issue      = 1'b0;
        issue_last = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    if (len != '0) begin
                        state_nxt  = RUN;
                        issue      = 1'b1;
                        issue_last = (len == LEN_ONE);
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            RUN: begin
                if (rem == '0) begin
                    state_nxt = DRAIN;
                end else if (credit_ok) begin
                    issue      = 1'b1;
                    issue_last = (rem == LEN_ONE);
                    if (rem == LEN_ONE) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && m_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, RAM port and command registers. addrb holds the address of the
    // most recent read, so every further read steps it by one and wraps
    // naturally at 2^AW. busy stays up through the DONE cycle for real
    // commands but never rises for a zero-length one.
    always_ff @(posedge clkb or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            reb       <= 1'b0;
            addrb     <= '0;
            rem       <= '0;
            busy_q    <= 1'b0;
            pend      <= '0;
            pend_last <= '0;
        end else begin
            state     <= state_nxt;
            reb       <= issue;
            pend      <= {pend[PEND_W-2:0], issue};
            pend_last <= {pend_last[PEND_W-2:0], issue_last};
            if (accept) begin
                if (len != '0) begin
                    addrb  <= base;
                    rem    <= len - LEN_ONE;
                    busy_q <= 1'b1;
                end
            end else if (issue) begin
                addrb <= addrb + AW'(1);
                rem   <= rem - LEN_ONE;
            end
            if (state == DONE) begin
                busy_q <= 1'b0;
            end
        end
    end

    // The oldest pending bit marks the cycle where doutb carries a word;
    // the last flag rides alongside and is stored next to the data.
    sdp_rd_fifo #(
        .W     (DW + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clkb      (clkb),
        .rst       (rst),
        .push      (pend[PEND_W-1]),
        .push_data ({pend_last[PEND_W-1], doutb}),
        .pop       (pop),
        .head_data (head),
        .empty     (fifo_empty),
        .occ       (occ)
    );

    assign m_valid = !fifo_empty;
    assign m_data  = head[DW-1:0];
    assign m_last  = m_valid && head[DW];
    assign busy    = busy_q;
    assign done    = (state == DONE);

`ifdef SDP_RD_STREAMER_STALL_CNT_EN
    // Backpressure statistics for the current command: restarts on every
    // accepted start and sticks at all-ones instead of wrapping.
    always_ff @(posedge clkb or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (accept) begin
            stall_cnt <= '0;
        end else if ((state == RUN || state == DRAIN) && m_valid && !m_ready
                     && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sdp_rd_streamer.sv
// ---------------------------------------------------------------------------
// tb_sdp_rd_streamer
// Self-checking bench for sdp_rd_streamer with AW=4, DW=4. A behavioural
// RAM with one-cycle registered read feeds the DUT. The reference model is
// the command itself: word k of a command must be ram[(base+k) mod 16],
// the last one flagged, reads must walk base, base+1, ... and never leave
// more than four words outstanding, and done/busy follow the command
// timeline. Build with SDP_RD_STREAMER_STALL_CNT_EN to cover stall_cnt.
// ---------------------------------------------------------------------------
module tb_sdp_rd_streamer;

    logic       clkb = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] base;
    logic [4:0] len;
    logic       busy;
    logic       done;
    logic       reb;
    logic [3:0] addrb;
    logic [3:0] doutb;
    logic       m_valid;
    logic [3:0] m_data;
    logic       m_last;
    logic       m_ready;
`ifdef SDP_RD_STREAMER_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    logic [3:0] ram [16];

    int total = 0;
    int bad   = 0;

    // Reference-model state for the command in progress
    int         cyc;
    int         issued;
    int         hs;
    int         stall_exp;
    int         cmd_len;
    int         cmd_mode;
    logic [3:0] cmd_base;
    bit         cmd_poke;
    bit         last_hs_prev;
    bit         prev_stall;
    bit         busy_exp;
    logic [3:0] prev_data;

    sdp_rd_streamer #(.AW(4), .DW(4)) dut (
        .clkb    (clkb),
        .rst     (rst),
        .start   (start),
        .base    (base),
        .len     (len),
        .busy    (busy),
        .done    (done),
        .reb     (reb),
        .addrb   (addrb),
        .doutb   (doutb),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_last  (m_last),
        .m_ready (m_ready)
`ifdef SDP_RD_STREAMER_STALL_CNT_EN
       ,.stall_cnt (stall_cnt)
`endif
    );

    // Free-running read clock, 10 time units per cycle
    always #5 clkb = ~clkb;

    // Behavioural RAM read port: one-cycle registered read
    always @(posedge clkb) begin
        if (reb === 1'b1) begin
            doutb <= ram[addrb];
        end
    end

    // Single comparison point: counts, asserts, reports
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Observe one cycle against the model, drive this cycle's inputs, then
    // advance to just after the next rising edge.
    task automatic step(output bit fin);
        bit done_exp;
        if (cyc == 1 && cmd_len != 0) busy_exp = 1'b1;
        done_exp = (cmd_len == 0 && cyc == 1) || last_hs_prev;
        checkOutput("done", 32'(done), 32'(done_exp));
        checkOutput("busy", 32'(busy), 32'(busy_exp));
        if (cmd_mode == 0) begin
            checkOutput("reb_timing", 32'(reb), 32'(cyc >= 1 && cyc <= cmd_len));
            checkOutput("valid_timing", 32'(m_valid), 32'(cyc >= 3 && cyc <= cmd_len + 2));
        end
        if (reb === 1'b1) begin
            checkOutput("addrb", 32'(addrb), 32'(4'(cmd_base + 4'(issued))));
            issued++;
        end
        checkOutput("credit", 32'(issued - hs <= 4), 32'd1);
        checkOutput("read_count", 32'(issued <= cmd_len), 32'd1);
        if (prev_stall) begin
            checkOutput("hold_valid", 32'(m_valid), 32'd1);
            checkOutput("hold_data", 32'(m_data), 32'(prev_data));
        end

        case (cmd_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
        if (cyc > 0) begin
            if (cmd_poke && cyc >= 3) begin
                start = 1'b1;
                base  = 4'($urandom);
                len   = 5'($urandom_range(0, 16));
            end else begin
                start = 1'b0;
            end
        end

        last_hs_prev = 1'b0;
        if (m_valid === 1'b1 && m_ready) begin
            checkOutput("data", 32'(m_data), 32'(ram[4'(cmd_base + 4'(hs))]));
            checkOutput("last", 32'(m_last), 32'(hs == cmd_len - 1));
            last_hs_prev = (hs == cmd_len - 1);
            hs++;
        end
        if (m_valid === 1'b1 && !m_ready) stall_exp++;
        prev_stall = (m_valid === 1'b1) && !m_ready;
        prev_data  = m_data;
`ifdef SDP_RD_STREAMER_STALL_CNT_EN
        if (done_exp) checkOutput("stall_cnt", 32'(stall_cnt), 32'(stall_exp));
`endif
        if (done_exp) busy_exp = 1'b0;
        fin = done_exp;
        @(posedge clkb);
        #1;
        cyc++;
    endtask

    // Run one command. mode 0: always ready, 1: ready 1,0,0,1 pattern,
    // 2: random ready. poke holds a random start from the third cycle
    // through the done cycle, which must be ignored.
    task automatic applyStimulus(input logic [3:0] b, input int l,
                                 input int mode, input bit poke);
        bit fin;
        cyc          = 0;
        issued       = 0;
        hs           = 0;
        stall_exp    = 0;
        cmd_base     = b;
        cmd_len      = l;
        cmd_mode     = mode;
        cmd_poke     = poke;
        last_hs_prev = 1'b0;
        prev_stall   = 1'b0;
        busy_exp     = 1'b0;
        base         = b;
        len          = 5'(l);
        start        = 1'b1;
        fin          = 1'b0;
        while (!fin && cyc < 300) step(fin);
        if (!fin) checkOutput("timeout", 32'd0, 32'd1);
        start = 1'b0;
        checkOutput("words", 32'(hs), 32'(l));
        checkOutput("reads", 32'(issued), 32'(l));
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("idle_done", 32'(done), 32'd0);
        checkOutput("idle_reb", 32'(reb), 32'd0);
        @(posedge clkb);
        #1;
        checkOutput("idle2_busy", 32'(busy), 32'd0);
        checkOutput("idle2_done", 32'(done), 32'd0);
        checkOutput("idle2_reb", 32'(reb), 32'd0);
        checkOutput("idle2_valid", 32'(m_valid), 32'd0);
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        base    = '0;
        len     = '0;
        m_ready = 1'b0;
        for (int i = 0; i < 16; i++) ram[i] = (i < 8) ? 4'(i + 1) : 4'($urandom);

        // Reset state
        #12;
        checkOutput("rst_reb", 32'(reb), 32'd0);
        checkOutput("rst_addrb", 32'(addrb), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_valid", 32'(m_valid), 32'd0);
        checkOutput("rst_last", 32'(m_last), 32'd0);
        @(posedge clkb);
        #1;
        rst = 1'b0;

        $display("[TB] directed: base 0 len 8 full rate");
        applyStimulus(4'd0, 8, 0, 1'b0);
        $display("[TB] directed: address wrap base 14 len 4");
        applyStimulus(4'd14, 4, 0, 1'b0);
        $display("[TB] directed: len 6 with toggling ready");
        applyStimulus(4'd2, 6, 1, 1'b0);
        $display("[TB] directed: zero length command");
        applyStimulus(4'd5, 0, 0, 1'b0);
        $display("[TB] directed: start while busy is ignored");
        applyStimulus(4'd7, 5, 1, 1'b1);
        applyStimulus(4'd3, 1, 0, 1'b1);

        $display("[TB] directed: reset in the middle of a command");
        m_ready = 1'b0;
        base    = 4'd3;
        len     = 5'd8;
        start   = 1'b1;
        @(posedge clkb);
        #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clkb);
            #1;
        end
        checkOutput("pre_rst_valid", 32'(m_valid), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_reb", 32'(reb), 32'd0);
        checkOutput("mid_rst_addrb", 32'(addrb), 32'd0);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_done", 32'(done), 32'd0);
        checkOutput("mid_rst_valid", 32'(m_valid), 32'd0);
        checkOutput("mid_rst_last", 32'(m_last), 32'd0);
        @(posedge clkb);
        #1;
        rst = 1'b0;
        applyStimulus(4'd9, 3, 2, 1'b0);

        $display("[TB] random commands");
        applyStimulus(4'($urandom), 16, 2, 1'b0);
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 16; i++) ram[i] = 4'($urandom);
            applyStimulus(4'($urandom), int'($urandom_range(0, 16)),
                          2, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
